// File: rtl/channel_rx_framer_if.sv
// ============================================================================
// Module      : channel_rx_framer_if
// Description : Bundles the channel word input and the payload/status outputs
//               of the receive framer.
//               master : the channel side. It drives rx_valid/rx_data and
//                        observes the payload and status outputs.
//               slave  : the framer. It consumes rx_* and drives the
//                        payload/status outputs.
//               Signals:
//                 rx_valid, rx_data[15:0]      channel word strobe and data
//                 payload_valid, payload_data  delivered payload word
//                 payload_sof, payload_eof     frame boundary flags
//                 locked                       framer is in LOCKED
//                 frame_cnt[15:0]              frames delivered
//                 sync_err_cnt[7:0]            missed syncs while locked
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface channel_rx_framer_if;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        payload_valid;
    logic [15:0] payload_data;
    logic        payload_sof;
    logic        payload_eof;
    logic        locked;
    logic [15:0] frame_cnt;
    logic [7:0]  sync_err_cnt;

    modport master (
        output rx_valid,
        output rx_data,
        input  payload_valid,
        input  payload_data,
        input  payload_sof,
        input  payload_eof,
        input  locked,
        input  frame_cnt,
        input  sync_err_cnt
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output payload_valid,
        output payload_data,
        output payload_sof,
        output payload_eof,
        output locked,
        output frame_cnt,
        output sync_err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/channel_rx_framer.sv
// ============================================================================
// Module      : channel_rx_framer
// Description : Receive-side frame synchroniser. It searches the channel word
//               stream for SYNC_WORD, allowing up to SYNC_TOL bit errors. It
//               locks after LOCK_CNT consecutive matched syncs and delivers
//               the FRAME_LEN payload words of each frame. A flywheel holds
//               lock until MISS_MAX consecutive sync slots fail.
//               Ports:
//                 clk_50  system clock, rising edge
//                 reset   synchronous, active-low
//                 bus     channel_rx_framer_if.slave (rx in, payload/status out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_rx_framer #(
    parameter logic [15:0] SYNC_WORD = 16'hA5C3,
    parameter int          FRAME_LEN = 8,
    parameter int          SYNC_TOL  = 1,
    parameter int          LOCK_CNT  = 2,
    parameter int          MISS_MAX  = 3
) (
    input  wire logic              clk_50,
    input  wire logic              reset,
    channel_rx_framer_if.slave     bus
);

    localparam logic [1:0] c_ST_SEARCH = 2'd0;
    localparam logic [1:0] c_ST_VERIFY = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    localparam logic [7:0] c_frame_len = FRAME_LEN[7:0];
    localparam logic [4:0] c_sync_tol  = SYNC_TOL[4:0];
    localparam logic [7:0] c_lock_cnt  = LOCK_CNT[7:0];
    localparam logic [7:0] c_miss_max  = MISS_MAX[7:0];

    logic [1:0]  r_state;
    logic [7:0]  r_pos;        // 0 = sync slot, 1..FRAME_LEN = payload slots
    logic [7:0]  r_good;
    logic [7:0]  r_miss;
    logic        r_pv;
    logic [15:0] r_pdata;
    logic        r_sof;
    logic        r_eof;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_err_cnt;

    logic [15:0] w_diff;
    logic [4:0]  w_dist;
    logic        w_match;
    logic [7:0]  w_pos_next;

    // Hamming distance between the incoming word and the sync pattern.
    always_comb begin
        w_diff = bus.rx_data ^ SYNC_WORD;
        w_dist = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_dist = w_dist + {4'd0, w_diff[i]};
        end
        w_match = (w_dist <= c_sync_tol);
    end

    assign w_pos_next = (r_pos == c_frame_len) ? 8'd0 : r_pos + 8'd1;

    always_ff @(posedge clk_50) begin
        if (!reset) begin
            r_state     <= c_ST_SEARCH;
            r_pos       <= 8'd0;
            r_good      <= 8'd0;
            r_miss      <= 8'd0;
            r_pv        <= 1'b0;
            r_pdata     <= 16'd0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_err_cnt   <= 8'd0;
        end else begin
            // Payload strobes are single-cycle pulses.
            r_pv  <= 1'b0;
            r_sof <= 1'b0;
            r_eof <= 1'b0;
            if (bus.rx_valid) begin
                case (r_state)
                    c_ST_SEARCH: begin
                        if (w_match) begin
                            r_good  <= 8'd1;
                            r_pos   <= 8'd1;
                            r_state <= (LOCK_CNT == 1) ? c_ST_LOCKED : c_ST_VERIFY;
                        end
                    end
                    c_ST_VERIFY: begin
                        if (r_pos == 8'd0) begin
                            if (w_match) begin
                                r_good <= r_good + 8'd1;
                                r_pos  <= 8'd1;
                                if (r_good + 8'd1 == c_lock_cnt) begin
                                    r_state <= c_ST_LOCKED;
                                end
                            end else begin
                                // The failing word is consumed here and not
                                // re-tested by SEARCH.
                                r_state <= c_ST_SEARCH;
                                r_good  <= 8'd0;
                                r_pos   <= 8'd0;
                            end
                        end else begin
                            r_pos <= w_pos_next;
                        end
                    end
                    c_ST_LOCKED: begin
                        if (r_pos == 8'd0) begin
                            if (w_match) begin
                                r_miss <= 8'd0;
                                r_pos  <= 8'd1;
                            end else begin
                                if (r_err_cnt != 8'hFF) begin
                                    r_err_cnt <= r_err_cnt + 8'd1;
                                end
                                if (r_miss + 8'd1 == c_miss_max) begin
                                    r_state <= c_ST_SEARCH;
                                    r_miss  <= 8'd0;
                                    r_good  <= 8'd0;
                                    r_pos   <= 8'd0;
                                end else begin
                                    // Flywheel: keep framing and deliver the
                                    // payload that follows the missed sync.
                                    r_miss <= r_miss + 8'd1;
                                    r_pos  <= 8'd1;
                                end
                            end
                        end else begin
                            r_pv    <= 1'b1;
                            r_pdata <= bus.rx_data;
                            r_sof   <= (r_pos == 8'd1);
                            r_eof   <= (r_pos == c_frame_len);
                            if (r_pos == c_frame_len) begin
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                            end
                            r_pos <= w_pos_next;
                        end
                    end
                    default: begin
                        r_state <= c_ST_SEARCH;
                    end
                endcase
            end
        end
    end

    assign bus.payload_valid = r_pv;
    assign bus.payload_data  = r_pdata;
    assign bus.payload_sof   = r_sof;
    assign bus.payload_eof   = r_eof;
    assign bus.locked        = (r_state == c_ST_LOCKED);
    assign bus.frame_cnt     = r_frame_cnt;
    assign bus.sync_err_cnt  = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_channel_rx_framer.sv
// ============================================================================
// Module      : tb_channel_rx_framer
// Description : Directed testbench for channel_rx_framer. Frames are driven
//               word by word and every output is compared against values
//               worked out by hand from the frame structure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_channel_rx_framer;

    logic clk_50 = 1'b0;
    logic reset  = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    channel_rx_framer_if bus ();

    channel_rx_framer u_dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word for exactly one rising edge, then settle past the edge.
    task automatic send_word(input logic v, input logic [15:0] d);
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk_50);
        #1;
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'hA5C3;
        reset = 1'b0;
        @(posedge clk_50);
        #1;
        reset = 1'b1;
        bus.rx_valid = 1'b0;
    endtask

    // One frame: sync word, then payload 1..8. When deliver is set every
    // payload word must appear one cycle after acceptance with sof/eof.
    task automatic send_frame(input logic [15:0] sync, input bit deliver);
        send_word(1'b1, sync);
        chk("sync_no_pv", {31'd0, bus.payload_valid}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            send_word(1'b1, 16'(k));
            if (deliver) begin
                chk("pv",   {31'd0, bus.payload_valid}, 32'd1);
                chk("data", {16'd0, bus.payload_data}, 32'(k));
                chk("sof",  {31'd0, bus.payload_sof}, (k == 1) ? 32'd1 : 32'd0);
                chk("eof",  {31'd0, bus.payload_eof}, (k == 8) ? 32'd1 : 32'd0);
            end else begin
                chk("no_pv", {31'd0, bus.payload_valid}, 32'd0);
            end
        end
    endtask

    // Two good frames: the first verifies, the second is delivered.
    task automatic lock_up();
        send_frame(16'hA5C3, 1'b0);
        chk("lock_up_pre", {31'd0, bus.locked}, 32'd0);
        send_frame(16'hA5C3, 1'b1);
        chk("lock_up", {31'd0, bus.locked}, 32'd1);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 16'd0;

        // Reset state
        do_reset();
        chk("rst_locked", {31'd0, bus.locked}, 32'd0);
        chk("rst_pv",     {31'd0, bus.payload_valid}, 32'd0);
        chk("rst_fcnt",   {16'd0, bus.frame_cnt}, 32'd0);
        chk("rst_ecnt",   {24'd0, bus.sync_err_cnt}, 32'd0);

        // 1: three back-to-back frames, lock on the 2nd sync
        send_frame(16'hA5C3, 1'b0);
        chk("t1_unlocked", {31'd0, bus.locked}, 32'd0);
        send_word(1'b1, 16'hA5C3);
        chk("t1_lock_edge", {31'd0, bus.locked}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            send_word(1'b1, 16'(k));
            chk("t1_pv",   {31'd0, bus.payload_valid}, 32'd1);
            chk("t1_data", {16'd0, bus.payload_data}, 32'(k));
        end
        send_frame(16'hA5C3, 1'b1);
        send_word(1'b0, 16'h0000);
        chk("t1_fcnt", {16'd0, bus.frame_cnt}, 32'd2);
        chk("t1_idle_pv", {31'd0, bus.payload_valid}, 32'd0);

        // 2: tolerance. A4C2 (2 errors) rejected, A5C2 (1 error) matches.
        do_reset();
        send_word(1'b1, 16'hA4C2);
        chk("t2_rej", {31'd0, bus.locked}, 32'd0);
        send_frame(16'hA5C2, 1'b0);
        send_word(1'b1, 16'hA5C3);
        chk("t2_lock", {31'd0, bus.locked}, 32'd1);
        for (int k = 1; k <= 8; k++) send_word(1'b1, 16'(k));

        // 3: one bad sync keeps lock; good sync clears miss
        do_reset();
        lock_up();
        send_frame(16'h0000, 1'b1);
        chk("t3_locked", {31'd0, bus.locked}, 32'd1);
        chk("t3_ecnt",   {24'd0, bus.sync_err_cnt}, 32'd1);
        send_frame(16'hA5C3, 1'b1);
        // Had miss not been cleared, two more misses would drop lock.
        send_frame(16'h0000, 1'b1);
        send_frame(16'h0000, 1'b1);
        chk("t3_miss_clr", {31'd0, bus.locked}, 32'd1);
        chk("t3_ecnt3",    {24'd0, bus.sync_err_cnt}, 32'd3);
        chk("t3_fcnt",     {16'd0, bus.frame_cnt}, 32'd5);

        // 4: three consecutive bad syncs drop lock
        do_reset();
        lock_up();
        send_frame(16'h0000, 1'b1);
        send_frame(16'hFFFF, 1'b1);
        chk("t4_still", {31'd0, bus.locked}, 32'd1);
        send_word(1'b1, 16'h1234);
        chk("t4_drop", {31'd0, bus.locked}, 32'd0);
        chk("t4_ecnt", {24'd0, bus.sync_err_cnt}, 32'd3);
        for (int k = 1; k <= 8; k++) begin
            send_word(1'b1, 16'(k));
            chk("t4_no_pv", {31'd0, bus.payload_valid}, 32'd0);
        end

        // 5: rx_valid toggling; output only after accepted words
        do_reset();
        lock_up();
        send_word(1'b1, 16'hA5C3);
        send_word(1'b0, 16'hA5C3);
        for (int k = 1; k <= 8; k++) begin
            send_word(1'b1, 16'(k));
            chk("t5_pv",   {31'd0, bus.payload_valid}, 32'd1);
            chk("t5_data", {16'd0, bus.payload_data}, 32'(k));
            chk("t5_sof",  {31'd0, bus.payload_sof}, (k == 1) ? 32'd1 : 32'd0);
            chk("t5_eof",  {31'd0, bus.payload_eof}, (k == 8) ? 32'd1 : 32'd0);
            send_word(1'b0, 16'hA5C3);
            chk("t5_gap_pv", {31'd0, bus.payload_valid}, 32'd0);
        end
        send_frame(16'hA5C3, 1'b1);
        chk("t5_fcnt", {16'd0, bus.frame_cnt}, 32'd3);
        chk("t5_ecnt", {24'd0, bus.sync_err_cnt}, 32'd0);

        // 6: reset mid-payload
        do_reset();
        lock_up();
        send_word(1'b1, 16'hA5C3);
        for (int k = 1; k <= 3; k++) send_word(1'b1, 16'(k));
        do_reset();
        chk("t6_locked", {31'd0, bus.locked}, 32'd0);
        chk("t6_pv",     {31'd0, bus.payload_valid}, 32'd0);
        chk("t6_data",   {16'd0, bus.payload_data}, 32'd0);
        chk("t6_sof",    {31'd0, bus.payload_sof}, 32'd0);
        chk("t6_fcnt",   {16'd0, bus.frame_cnt}, 32'd0);
        for (int k = 4; k <= 8; k++) begin
            send_word(1'b1, 16'(k));
            chk("t6_tail_pv", {31'd0, bus.payload_valid}, 32'd0);
        end
        send_frame(16'hA5C3, 1'b0);
        chk("t6_not_yet", {31'd0, bus.locked}, 32'd0);
        send_frame(16'hA5C3, 1'b1);
        chk("t6_relock", {31'd0, bus.locked}, 32'd1);
        chk("t6_fcnt1",  {16'd0, bus.frame_cnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
